req_queue_mc: RTL

Multi-channel, parametrised request queue between the CPU-side memory requesters (I-cache, D-cache, DMA, ...) and the MIG command sequencer. NCH requesters present read or write commands. A round-robin arbiter accepts at most one per cycle into a DEPTH-entry FIFO, tagging each entry with its source channel ID so the sequencer can route read data back. The block provides exact occupancy, an almost-full flag, and a valid/ready output handshake with correct simultaneous push/pop accounting.

---
 rtl/req_queue_mc_pkg.sv | 35 +++
 rtl/sfifo_1r1w.sv | 34 +++
 rtl/req_queue_mc.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/req_queue_mc_pkg.sv
// req_queue_mc_pkg
// Shared definitions for the request queue and for the MIG command sequencer
// that decodes the queue entries.
//   - clog2 / chw_of : derived-width helpers (channel-ID width is at least 1)
//   - ent_*          : queue entry layout {RD, ID, ADDR}, ADDR in the LSBs
package req_queue_mc_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int chw_of(input int nch);
        return (nch <= 1) ? 1 : clog2(nch);
    endfunction

    function automatic int ent_addr_lsb();
        return 0;
    endfunction

    function automatic int ent_id_lsb(input int aw);
        return aw;
    endfunction

    function automatic int ent_rd_bit(input int aw, input int chw);
        return aw + chw;
    endfunction

    function automatic int ent_width(input int aw, input int chw);
        return aw + chw + 1;
    endfunction

endpackage

// File: rtl/sfifo_1r1w.sv
// sfifo_1r1w
// Simple one-write / one-read storage array used as FIFO backing store.
// Write is synchronous, read is combinational. Contents are not reset; the
// owner qualifies the read data with its own valid/occupancy state.
//   clk       : clock
//   ram_wen   : write enable
//   ram_waddr : write address
//   ram_wdata : write data
//   ram_raddr : read address
//   ram_rdata : read data (combinational)
module sfifo_1r1w #(
    parameter int SFIFODW = 8,
    parameter int SFIFOAW = 3,
    parameter int SFIFODP = 8
) (
    input  logic               clk,
    input  logic               ram_wen,
    input  logic [SFIFOAW-1:0] ram_waddr,
    input  logic [SFIFODW-1:0] ram_wdata,
    input  logic [SFIFOAW-1:0] ram_raddr,
    output logic [SFIFODW-1:0] ram_rdata
);

    logic [SFIFODW-1:0] mem_q [SFIFODP];

    always_ff @(posedge clk) begin
        if (ram_wen) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
    end

    assign ram_rdata = mem_q[ram_raddr];

endmodule

// File: rtl/req_queue_mc.sv
// req_queue_mc
// Round-robin arbitrated request queue between NCH memory requesters and the
// MIG command sequencer. One request is accepted per cycle into a DEPTH-entry
// FIFO; each entry carries its source channel ID for read-data routing.
//   mclk, mrst_n  : clock, asynchronous active-low reset
//   cmd_req       : per-channel request, held until acked
//   cmd_rd        : per-channel type (1 = read)
//   cmd_addr      : channel i address at [i*AW +: AW]
//   cmd_ack       : one-hot/zero accept, same cycle as the request
//   q_valid/ready : head handshake toward the sequencer
//   q_addr/rd/id  : head entry fields, zero while the queue is empty
//   q_count       : occupancy 0..DEPTH
//   q_afull       : q_count >= AFULL
module req_queue_mc
    import req_queue_mc_pkg::*;
#(
    parameter  int NCH   = 2,
    parameter  int AW    = 32,
    parameter  int DEPTH = 8,
    parameter  int AFULL = 6,
    localparam int CHW   = chw_of(NCH),
    localparam int PW    = clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              mclk,
    input  logic              mrst_n,
    input  logic [NCH-1:0]    cmd_req,
    input  logic [NCH-1:0]    cmd_rd,
    input  logic [NCH*AW-1:0] cmd_addr,
    output logic [NCH-1:0]    cmd_ack,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [AW-1:0]     q_addr,
    output logic              q_rd,
    output logic [CHW-1:0]    q_id,
    output logic [CW-1:0]     q_count,
    output logic              q_afull
);

    localparam int DW       = ent_width(AW, CHW);
    localparam int ADDR_LSB = ent_addr_lsb();
    localparam int ID_LSB   = ent_id_lsb(AW);
    localparam int RD_BIT   = ent_rd_bit(AW, CHW);
    localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

    logic [CHW-1:0] rr_q, rr_d;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q, count_d;

    logic [NCH-1:0] req_rot;
    logic [CHW-1:0] off, grant;
    logic [CHW:0]   sum, nxt;
    logic           any_req, full, push, pop;
    logic           rd_g;
    logic [AW-1:0]  addr_g;
    logic [DW-1:0]  wdata, rdata;

    // Rotate the request vector so that bit 0 is the channel at rr_q; the
    // lowest set bit is then the round-robin winner's offset from rr_q.
    always_comb begin
        req_rot = NCH'({cmd_req, cmd_req} >> rr_q);
        off     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_rot[k]) off = CHW'(k);
        end
        sum   = {1'b0, rr_q} + {1'b0, off};
        grant = (sum >= NCH_W) ? CHW'(sum - NCH_W) : CHW'(sum);
        nxt   = {1'b0, grant} + (CHW+1)'(1);
        rr_d  = (nxt >= NCH_W) ? '0 : nxt[CHW-1:0];
    end

    assign any_req = |cmd_req;
    assign full    = (count_q == CW'(DEPTH));
    assign q_valid = (count_q != '0);
    // Reset gating keeps acks low for the whole time mrst_n is asserted.
    assign push    = any_req & ~full & mrst_n;
    assign pop     = q_valid & q_ready;

    always_comb begin
        cmd_ack = '0;
        rd_g    = 1'b0;
        addr_g  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == CHW'(i)) begin
                cmd_ack[i] = push;
                rd_g       = cmd_rd[i];
                addr_g     = cmd_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        wdata                  = '0;
        wdata[RD_BIT]          = rd_g;
        wdata[ID_LSB +: CHW]   = grant;
        wdata[ADDR_LSB +: AW]  = addr_g;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                rr_q   <= rr_d;
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    sfifo_1r1w #(
        .SFIFODW (DW),
        .SFIFOAW (PW),
        .SFIFODP (DEPTH)
    ) u_store (
        .clk       (mclk),
        .ram_wen   (push),
        .ram_waddr (wptr_q),
        .ram_wdata (wdata),
        .ram_raddr (rptr_q),
        .ram_rdata (rdata)
    );

    assign q_addr  = q_valid ? rdata[ADDR_LSB +: AW] : '0;
    assign q_rd    = q_valid ? rdata[RD_BIT] : 1'b0;
    assign q_id    = q_valid ? rdata[ID_LSB +: CHW] : '0;
    assign q_count = count_q;
    assign q_afull = (count_q >= CW'(AFULL));

endmodule
